spi_slave_tx: RTL and testbench
===============================

# spi_slave_tx

SPI responder transmitter: the far-end counterpart of the 40-bit SPI receive controller. It sits in the peripheral-side design, oversamples the master's SCLK and SS in the local clock domain, and shifts a 40-bit word out on MISO, MSB first, once per SS-low frame. A one-deep holding buffer with valid/ready lets the local logic queue the next frame while the current one is shifting.

## Interface
- WIDTH, 40: frame length in bits.
- SYNC_STAGES, 2: flip-flops in the SCLK/SS synchronizers (≥2).
- clk  in  1  system clock; must be ≥8× SCLK frequency.
- rst  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- SCLK  in  1  master serial clock, idle low, async to clk.
- SS  in  1  master slave-select, active low, async to clk.
- MISO  out  1  serial data to master.
- MISO_oe  out  1  tri-state enable for MISO pad, high while selected.
- DIN  in  WIDTH  next frame word.
- din_valid  in  1  DIN offered.
- din_ready  out  1  holding buffer empty; write accepted when din_valid & din_ready.
- frame_done  out  1  one-clk pulse: frame ended with exactly WIDTH SCLK falls.
- frame_abort  out  1  one-clk pulse: SS rose with fewer than WIDTH falls.
- underrun  out  1  one-clk pulse: frame started with holding buffer empty.

## Operation
- SCLK and SS pass through SYNC_STAGES synchronizers plus one history flop; edges are detected on synchronized values. SS sync chain resets to 0, SCLK chain to 0.
- Holding buffer (hold_q, hold_full) and last-sent register (last_q). Write sets hold_full, clears din_ready.
- States: IDLE, SHIFT.
- IDLE: MISO=0, MISO_oe=0. On SS falling edge: shreg ← hold_full ? hold_q : last_q; last_q ← same value; hold_full cleared; bitcnt ← 0; underrun pulses if hold_full was 0; go SHIFT.
- SHIFT: MISO_oe=1, MISO=shreg[WIDTH-1]. On each SCLK falling edge: shreg ← {shreg[WIDTH-2:0],0}; bitcnt ← bitcnt+1, saturating at WIDTH. Falls beyond WIDTH shift zeros (MISO=0).
- SHIFT, SS rising edge: frame_done if bitcnt==WIDTH, else frame_abort; go IDLE.
- Simultaneous SCLK fall and SS rise in the same clk: the fall is counted first, then completion evaluated (master's last sample edge coincides with SS deassertion).
- Write in the same cycle as frame-start load: load uses pre-cycle hold state; the write lands in hold for the next frame.
- Reset mid-frame: back to IDLE, outputs to reset values; with SS sync reset to 0, a frame in progress is ignored until SS goes high then low again.
- SCLK edges while in IDLE are ignored.

## Timing
- Reset values: MISO=0, MISO_oe=0, din_ready=1, frame_done=0, frame_abort=0, underrun=0; hold_q, last_q, shreg, bitcnt=0.
- SS falling at pin → MISO driven with bit WIDTH-1 within SYNC_STAGES+2 clk cycles; master's first sample is one SCLK period later.
- Master samples MISO on SCLK falling edge; responder changes MISO SYNC_STAGES+2 clk after that edge (hold satisfied) and before the next falling edge (setup guaranteed by ≥8× ratio).
- frame_done/frame_abort asserted SYNC_STAGES+2 clk after SS rise at pin.
- din_ready returns to 1 the cycle after frame-start load.
- Minimum SS-high gap between frames: 2 SCLK periods.

## Test plan
- Reset with SS high, write DIN=0xA5_1234_5678, master frame of 40 clocks at clk/8 → master receives 0xA512345678, frame_done one pulse, underrun 0, din_ready back to 1.
- Two back-to-back frames, second DIN=0xFF00FF00FF written mid-first-frame → frames yield 0xA512345678 then 0xFF00FF00FF; din_ready low from write until second frame start.
- Second frame with no write → master receives repeated 0xFF00FF00FF, underrun pulses once at frame start.
- SS raised after 17 SCLK falls → frame_abort pulse, no frame_done; next frame sends held word from bit 39.
- 44 SCLK falls in one frame → first 40 bits correct, last 4 bits 0, frame_done pulse.
- Reset asserted at bit 20 with SS held low → MISO_oe=0, no transmission until SS high then low; following frame correct.

Source files
------------

// File: rtl/spi_slave_tx_if.sv
// Bus bundle for the SPI responder transmitter: SPI pins plus the local
// valid/ready word feed and the per-frame status pulses.
interface spi_slave_tx_if #(
  parameter int WIDTH = 40
);
  logic             SCLK;
  logic             SS;
  logic             MISO;
  logic             MISO_oe;
  logic [WIDTH-1:0] DIN;
  logic             din_valid;
  logic             din_ready;
  logic             frame_done;
  logic             frame_abort;
  logic             underrun;

  modport slave (
    input  SCLK, SS, DIN, din_valid,
    output MISO, MISO_oe, din_ready, frame_done, frame_abort, underrun
  );

  modport master (
    output SCLK, SS, DIN, din_valid,
    input  MISO, MISO_oe, din_ready, frame_done, frame_abort, underrun
  );
endinterface

// File: rtl/spi_slave_tx.sv
// SPI responder transmitter: oversamples SCLK/SS, shifts a WIDTH-bit word out
// MSB first per SS-low frame, with a one-deep holding buffer for the next word.
module spi_slave_tx #(
  parameter int WIDTH       = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  spi_slave_tx_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q;
  logic                   sclk_hist_q, ss_hist_q;
  logic                   sclk_s, ss_s, sclk_fall_s, ss_fall_s, ss_rise_s;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             ready_q, ready_d;
  logic             miso_q, miso_d;
  logic             oe_q, oe_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             und_q, und_d;

  // Synchronizers plus one history flop for SCLK and SS edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      sclk_hist_q <= 1'b0;
      ss_hist_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.SS};
      sclk_hist_q <= sclk_s;
      ss_hist_q   <= ss_s;
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign sclk_fall_s = sclk_hist_q & ~sclk_s;
  assign ss_fall_s   = ss_hist_q & ~ss_s;
  assign ss_rise_s   = ~ss_hist_q & ss_s;

  // Frame FSM, shifter, holding buffer and registered output next-state.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    hold_d   = hold_q;
    last_d   = last_q;
    bitcnt_d = bitcnt_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    und_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall_s) begin
          if (!ready_q) begin
            shreg_d = hold_q;
            last_d  = hold_q;
          end else begin
            shreg_d = last_q;
          end
          und_d    = ready_q;
          ready_d  = 1'b1;
          bitcnt_d = '0;
          state_d  = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (sclk_fall_s) begin
          shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
          bitcnt_d = (bitcnt_q == CNT_MAX) ? bitcnt_q : bitcnt_q + CW'(1);
        end else begin
          shreg_d = shreg_q;
        end
        // The coincident last fall is already counted in bitcnt_d.
        if (ss_rise_s) begin
          done_d  = (bitcnt_d == CNT_MAX);
          abort_d = (bitcnt_d != CNT_MAX);
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A write beside a frame-start load lands in hold for the next frame.
    if (bus.din_valid && ready_q) begin
      hold_d  = bus.DIN;
      ready_d = 1'b0;
    end else begin
      hold_d = hold_d;
    end
    oe_d   = (state_d == SHIFT);
    miso_d = (state_d == SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      hold_q   <= '0;
      last_q   <= '0;
      bitcnt_q <= '0;
      ready_q  <= 1'b1;
      miso_q   <= 1'b0;
      oe_q     <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
      bitcnt_q <= bitcnt_d;
      ready_q  <= ready_d;
      miso_q   <= miso_d;
      oe_q     <= oe_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      und_q    <= und_d;
    end
  end

  assign bus.MISO        = miso_q;
  assign bus.MISO_oe     = oe_q;
  assign bus.din_ready   = ready_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_abort = abort_q;
  assign bus.underrun    = und_q;
endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed bench for spi_slave_tx: a table of master frames with hand-computed
// received words and status pulses, plus a reset-mid-frame sequence.
module tb_spi_slave_tx;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n_done, n_abort, n_und;

  spi_slave_tx_if #(.WIDTH(40)) bus ();

  spi_slave_tx #(.WIDTH(40), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1)  n_done  = n_done + 1;
    if (bus.frame_abort === 1'b1) n_abort = n_abort + 1;
    if (bus.underrun === 1'b1)    n_und   = n_und + 1;
  end

  typedef struct {
    bit          pre_wr;
    logic [39:0] pre_word;
    int          nfalls;
    int          mid_at;
    logic [39:0] mid_word;
    bit          simul;
    logic [63:0] exp_rx;
    int          exp_done;
    int          exp_abort;
    int          exp_und;
    logic        exp_ready;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [39:0] w);
    int n;
    n = 0;
    while (bus.din_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    if (bus.din_ready !== 1'b1) begin
      errors = errors + 1;
      checks = checks + 1;
      $display("FAIL write_timeout: din_ready stuck at %b, expected 1", bus.din_ready);
    end
    bus.DIN       = w;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  task automatic run_frame(input int nfalls, input int mid_at, input logic [39:0] mid_word,
                           input bit simul, output logic [63:0] rx, output logic oe_first);
    rx       = '0;
    oe_first = 1'b0;
    @(negedge clk);
    bus.SS = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nfalls; i++) begin
      bus.SCLK = 1'b1;
      if (i == mid_at) begin
        bus.DIN       = mid_word;
        bus.din_valid = 1'b1;
      end
      repeat (4) @(negedge clk);
      bus.din_valid = 1'b0;
      if (i == 0) oe_first = bus.MISO_oe;
      rx       = {rx[62:0], bus.MISO};
      bus.SCLK = 1'b0;
      if (simul && i == nfalls - 1) bus.SS = 1'b1;
      repeat (4) @(negedge clk);
    end
    bus.SS = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    logic [63:0] rx;
    logic        oe_first;
    int          d0, a0, u0;
    logic        oe_any;

    checks = 0; errors = 0;
    n_done = 0; n_abort = 0; n_und = 0;

    vecs[0] = '{1'b1, 40'hA512345678, 40, 20, 40'hFF00FF00FF, 1'b0, 64'hA512345678,  1, 0, 0, 1'b0};
    vecs[1] = '{1'b0, 40'h0,          40, -1, 40'h0,          1'b1, 64'hFF00FF00FF,  1, 0, 0, 1'b1};
    vecs[2] = '{1'b0, 40'h0,          40, -1, 40'h0,          1'b0, 64'hFF00FF00FF,  1, 0, 1, 1'b1};
    vecs[3] = '{1'b1, 40'h123456789A, 17, 10, 40'h0F1E2D3C4B, 1'b0, 64'h2468,        0, 1, 0, 1'b0};
    vecs[4] = '{1'b0, 40'h0,          40, -1, 40'h0,          1'b0, 64'h0F1E2D3C4B,  1, 0, 0, 1'b1};
    vecs[5] = '{1'b1, 40'hC35A5A0110, 44, -1, 40'h0,          1'b0, 64'hC35A5A01100, 1, 0, 0, 1'b1};

    rst = 1'b0; bus.SS = 1'b1; bus.SCLK = 1'b0; bus.DIN = '0; bus.din_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso",  {63'd0, bus.MISO},        64'd0);
    chk("rst_oe",    {63'd0, bus.MISO_oe},     64'd0);
    chk("rst_ready", {63'd0, bus.din_ready},   64'd1);
    chk("rst_pulse", {61'd0, bus.frame_done, bus.frame_abort, bus.underrun}, 64'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].pre_wr) begin
        write_word(vecs[v].pre_word);
        chk($sformatf("v%0d_ready_after_wr", v), {63'd0, bus.din_ready}, 64'd0);
      end
      d0 = n_done; a0 = n_abort; u0 = n_und;
      run_frame(vecs[v].nfalls, vecs[v].mid_at, vecs[v].mid_word, vecs[v].simul, rx, oe_first);
      chk($sformatf("v%0d_rx", v),    rx, vecs[v].exp_rx);
      chk($sformatf("v%0d_oe", v),    {63'd0, oe_first}, 64'd1);
      chk($sformatf("v%0d_done", v),  64'(n_done - d0),  64'(vecs[v].exp_done));
      chk($sformatf("v%0d_abort", v), 64'(n_abort - a0), 64'(vecs[v].exp_abort));
      chk($sformatf("v%0d_und", v),   64'(n_und - u0),   64'(vecs[v].exp_und));
      chk($sformatf("v%0d_ready", v), {63'd0, bus.din_ready}, {63'd0, vecs[v].exp_ready});
      chk($sformatf("v%0d_idle_oe", v), {62'd0, bus.MISO_oe, bus.MISO}, 64'd0);
    end

    // Reset at bit 20 with SS held low: the ongoing frame must stay silent.
    write_word(40'h5555AAAA33);
    d0 = n_done; a0 = n_abort; u0 = n_und;
    @(negedge clk);
    bus.SS = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      bus.SCLK = 1'b1; repeat (4) @(negedge clk);
      bus.SCLK = 1'b0; repeat (4) @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_ready", {63'd0, bus.din_ready}, 64'd1);
    chk("mid_rst_oe",    {63'd0, bus.MISO_oe},   64'd0);
    oe_any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.SCLK = 1'b1; repeat (4) @(negedge clk);
      oe_any = oe_any | bus.MISO_oe | bus.MISO;
      bus.SCLK = 1'b0; repeat (4) @(negedge clk);
    end
    bus.SS = 1'b1;
    repeat (16) @(negedge clk);
    chk("mid_rst_silent", {63'd0, oe_any}, 64'd0);
    chk("mid_rst_pulses", 64'((n_done - d0) + (n_abort - a0) + (n_und - u0)), 64'd0);

    write_word(40'h3C3C3C3C3C);
    d0 = n_done; u0 = n_und;
    run_frame(40, -1, 40'h0, 1'b0, rx, oe_first);
    chk("post_rst_rx",   rx, 64'h3C3C3C3C3C);
    chk("post_rst_done", 64'(n_done - d0), 64'd1);
    chk("post_rst_und",  64'(n_und - u0),  64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
